// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline: widths, reset PC, bubble
// encoding and the IF/ID latch payload used by fetch and decode.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
  } ifid_t;

  // Branch targets are word aligned by clearing the low two bits; no trap.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// Handshake: there is no valid/ready pair on this bus. Control inputs are
// sampled on every rising clock edge, imem_rdata_i must be a combinational
// read of imem_addr_o, and ifid_valid_o qualifies the IF/ID fields.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            stall_i;
  logic            flush_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [XLEN-1:0] imem_addr_o;
  logic [31:0]     imem_rdata_i;
  logic            ifid_valid_o;
  logic [XLEN-1:0] ifid_pc_o;
  logic [XLEN-1:0] ifid_pc4_o;
  logic [31:0]     ifid_instr_o;
  logic [31:0]     fetch_count_o;

  // Fetch stage side.
  modport slave (
    input  stall_i, flush_i, redirect_valid_i, redirect_pc_i, imem_rdata_i,
    output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
    output fetch_count_o
  );

  // Hazard unit / branch resolver / memory / decode side.
  modport master (
    output stall_i, flush_i, redirect_valid_i, redirect_pc_i, imem_rdata_i,
    input  imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
    input  fetch_count_o
  );

endinterface

// File: rtl/ifid_reg.sv
// Pipeline latch with bubble/hold/load controls. Bubble beats hold: a
// squashed slot still records the incoming pc/pc4 but is marked invalid
// and carries the NOP encoding. Reusable for later pipeline latches.
module ifid_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  hold_i,
  input  logic  bubble_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t q_q;
  ifid_t q_d;

  // Next latch contents: bubble > hold > load.
  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d       = d_i;
      q_d.valid = 1'b0;
      q_d.instr = NOP;
    end else if (!hold_i) begin
      q_d = d_i;
    end
  end

  // Latch register with synchronous reset to an empty bubble at pc 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q.valid <= 1'b0;
      q_q.pc    <= '0;
      q_q.pc4   <= '0;
      q_q.instr <= NOP;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the instruction memory address and
// fills the IF/ID latch. Priority per edge: reset > redirect > stall > advance.
// flush_i squashes the slot being fetched without touching the PC rule.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RST_PC = RESET_PC,
  parameter logic [31:0]     NOP    = NOP_INSTR
) (
  input logic         clock,
  input logic         reset,
  fetch_stage_if.slave bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [31:0]     count_q;
  logic [31:0]     count_d;
  logic            bubble;
  logic            load;
  ifid_t           ifid_d;
  ifid_t           ifid_q;

  assign bubble = bus.redirect_valid_i | bus.flush_i;
  assign load   = !bubble && !bus.stall_i;

  // Next PC and retired-fetch count; the +4 wraps naturally at 2^XLEN.
  always_comb begin
    pc_d    = pc_q + XLEN'(4);
    count_d = count_q;
    if (bus.redirect_valid_i) begin
      pc_d = align_pc(bus.redirect_pc_i);
    end else if (bus.stall_i) begin
      pc_d = pc_q;
    end
    if (load) begin
      count_d = count_q + 32'd1;
    end
  end

  // PC and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RST_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Candidate IF/ID contents for the instruction currently at pc_q.
  always_comb begin
    ifid_d.valid = 1'b1;
    ifid_d.pc    = pc_q;
    ifid_d.pc4   = pc_q + XLEN'(4);
    ifid_d.instr = bus.imem_rdata_i;
  end

  ifid_reg #(.NOP(NOP)) u_ifid (
    .clk_i   (clock),
    .rst_i   (reset),
    .hold_i  (bus.stall_i),
    .bubble_i(bubble),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign bus.imem_addr_o   = pc_q;
  assign bus.ifid_valid_o  = ifid_q.valid;
  assign bus.ifid_pc_o     = ifid_q.pc;
  assign bus.ifid_pc4_o    = ifid_q.pc4;
  assign bus.ifid_instr_o  = ifid_q.instr;
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural model predicts each edge's outcome,
// the prediction is queued when the step is driven and popped after the edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int W = 161;  // {valid, ifid_pc, ifid_pc4, instr, count, pc_q}

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  logic [W-1:0] exp_q[$];

  // model state
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_cnt;
  logic        m_valid;

  fetch_stage_if bus_if ();

  fetch_stage dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Instruction memory: word i holds 0x1000_0000 + i.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign bus_if.imem_rdata_i = imem_word(bus_if.imem_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, predict, wait for the edge, score.
  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic rv, input logic [31:0] rpc);
    logic [31:0] rd;
    logic [W-1:0] e;
    bus_if.stall_i          = st;
    bus_if.flush_i          = fl;
    bus_if.redirect_valid_i = rv;
    bus_if.redirect_pc_i    = rpc;
    reset                   = rst;
    rd = imem_word(m_pc);
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP;
      m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_cnt = 32'h0;
    end else begin
      if (rv || fl) begin
        m_valid = 1'b0; m_instr = NOP; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
      end else if (!st) begin
        m_valid = 1'b1; m_instr = rd; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
      if (rv) m_pc = {rpc[31:2], 2'b00};
      else if (!st) m_pc = m_pc + 32'd4;
    end
    exp_q.push_back({m_valid, m_ifpc, m_ifpc4, m_instr, m_cnt, m_pc});
    @(posedge clock);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ifid_valid", {31'b0, bus_if.ifid_valid_o}, {31'b0, e[160]});
      check("ifid_pc", bus_if.ifid_pc_o, e[159:128]);
      check("ifid_pc4", bus_if.ifid_pc4_o, e[127:96]);
      check("ifid_instr", bus_if.ifid_instr_o, e[95:64]);
      check("fetch_count", bus_if.fetch_count_o, e[63:32]);
      check("pc_q", bus_if.imem_addr_o, e[31:0]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_pc = 0; m_ifpc = 0; m_ifpc4 = 0; m_instr = NOP; m_cnt = 0; m_valid = 0;

    // reset state
    step(1, 0, 0, 0, 0);
    check("rst_valid", {31'b0, bus_if.ifid_valid_o}, 32'd0);
    check("rst_instr", bus_if.ifid_instr_o, NOP);
    check("rst_count", bus_if.fetch_count_o, 32'd0);

    // free run: first edge latches RESET_PC
    step(0, 0, 0, 0, 0);
    check("edge1_pc", bus_if.ifid_pc_o, 32'd0);
    check("edge1_instr", bus_if.ifid_instr_o, 32'h1000_0000);
    check("edge1_valid", {31'b0, bus_if.ifid_valid_o}, 32'd1);
    step(0, 0, 0, 0, 0);

    // stall two cycles at PC=8
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("stall_pcq", bus_if.imem_addr_o, 32'd8);
    check("stall_ifpc", bus_if.ifid_pc_o, 32'd4);
    check("stall_count", bus_if.fetch_count_o, 32'd2);
    step(0, 0, 0, 0, 0);
    check("release_pc", bus_if.ifid_pc_o, 32'd8);
    step(0, 0, 0, 0, 0);
    check("edge4_pc", bus_if.ifid_pc_o, 32'd12);
    check("edge4_count", bus_if.fetch_count_o, 32'd4);

    // redirect to 0x40 at PC=16
    step(0, 0, 0, 1, 32'h0000_0040);
    check("redir_valid", {31'b0, bus_if.ifid_valid_o}, 32'd0);
    check("redir_instr", bus_if.ifid_instr_o, NOP);
    step(0, 0, 0, 0, 0);
    check("redir_tgt_pc", bus_if.ifid_pc_o, 32'h40);
    check("redir_count", bus_if.fetch_count_o, 32'd5);

    // redirect + stall, misaligned target
    step(0, 1, 0, 1, 32'h0000_0083);
    check("rs_pcq", bus_if.imem_addr_o, 32'h80);
    check("rs_valid", {31'b0, bus_if.ifid_valid_o}, 32'd0);
    step(0, 0, 0, 0, 0);

    // flush alone, then flush with stall
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // wrap at top of address space
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    check("wrap_pc", bus_if.ifid_pc_o, 32'hFFFF_FFFC);
    check("wrap_pc4", bus_if.ifid_pc4_o, 32'd0);
    step(0, 0, 0, 0, 0);
    check("wrap_next_pc", bus_if.ifid_pc_o, 32'd0);

    // reset mid-run overrides stall and redirect
    step(1, 1, 0, 1, 32'h0000_0100);
    check("mrst_pcq", bus_if.imem_addr_o, 32'd0);
    check("mrst_count", bus_if.fetch_count_o, 32'd0);
    step(0, 0, 0, 0, 0);
    check("mrst_next_valid", {31'b0, bus_if.ifid_valid_o}, 32'd1);

    // random mix
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core that runs merge sort; it is the upstream feeder of the decode stage inside Top.
- Holds the PC, drives the instruction-memory read port, and registers the IF/ID pipeline latch.
- Honours stall from the hazard unit and redirect/flush from the branch resolver in EX.
- Keeps a retired-fetch counter for the simulation bench.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard unit load-use stall; hold PC and IF/ID.
- flush_i  in  1  squash the instruction currently being fetched.
- redirect_valid_i  in  1  taken branch/jump resolved in EX.
- redirect_pc_i  in  XLEN  target PC for the redirect.
- imem_addr_o  out  XLEN  instruction memory address, combinationally equal to pc_q.
- imem_rdata_i  in  32  instruction word, combinational read of imem_addr_o.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_pc_o  out  XLEN  PC of the IF/ID instruction.
- ifid_pc4_o  out  XLEN  ifid_pc_o + 4.
- ifid_instr_o  out  32  instruction word, or NOP_INSTR when invalid.
- fetch_count_o  out  32  count of valid instructions latched into IF/ID.

Behaviour:
- Reset (sampled on the clock edge):
  - pc_q = RESET_PC; ifid_valid_o = 0; ifid_instr_o = NOP_INSTR.
  - ifid_pc_o = 0; ifid_pc4_o = 0; fetch_count_o = 0.
  - Reset asserted mid-run overrides every other input on that edge.
- Priority per edge: reset > redirect_valid_i > stall_i > normal advance.
- PC next:
  - redirect: {redirect_pc_i[XLEN-1:2],2'b00}. Low bits are forced to zero and no misalign trap is raised.
  - else stall: hold.
  - else pc_q + 4, modulo 2^XLEN; wraps from 32'hFFFF_FFFC to 0.
- IF/ID next:
  - redirect or flush_i: bubble (valid=0, instr=NOP_INSTR). ifid_pc_o and ifid_pc4_o take the current pc_q / pc_q+4. This applies even when stall_i is high.
  - else stall: hold all IF/ID fields.
  - else latch valid=1, instr=imem_rdata_i, pc=pc_q, pc4=pc_q+4.
- flush_i without redirect: IF/ID becomes a bubble; PC follows the stall/advance rule.
- fetch_count_o increments by 1 only on edges where valid=1 is latched. Wraps 32'hFFFF_FFFF -> 0.
- Latency:
  - PC -> IF/ID takes 1 cycle.
  - Redirect at edge N: target instruction is presented on imem at cycle N+1 and appears valid in IF/ID after edge N+1.
  - Exactly one bubble follows a redirect.
- First edge after reset deassert latches the instruction at RESET_PC as valid.
- No X propagation: all outputs are driven from registers or pc_q at all times.

Decomposition:
- Shared package riscv_pkg holds XLEN, RESET_PC, NOP_INSTR, and an ifid_t struct {valid, pc, pc4, instr} used by fetch and decode.
- One natural sub-module: ifid_reg. It is the pipeline latch with hold/bubble/load controls and is reusable for ID/EX.
- PC logic and the counter stay inline in fetch_stage.

Test Plan:
- Reset then free-run with imem[i]=32'h1000_0000+i:
  - after edge 1: ifid_pc=0, instr=32'h1000_0000, valid=1.
  - after edge 4: ifid_pc=12, fetch_count=4.
- Stall high for 2 cycles at PC=8:
  - pc_q stays 8 and IF/ID holds PC=4 for both cycles.
  - fetch_count does not change.
  - after release, next IF/ID PC=8.
- Redirect to 32'h0000_0040 at PC=16:
  - next IF/ID is a bubble (valid=0, instr=32'h0000_0013).
  - the following IF/ID has PC=0x40, valid=1.
  - fetch_count skips exactly one increment.
- Redirect and stall asserted together with redirect_pc_i=32'h0000_0083:
  - redirect wins; pc_q=0x80 and IF/ID is a bubble.
- Preload pc_q=32'hFFFF_FFFC via redirect, then free-run:
  - IF/ID PC=0xFFFF_FFFC with pc4=0.
  - next IF/ID PC=0.
- Reset asserted for 1 cycle while stall=1 and redirect=1 mid-run:
  - pc_q=RESET_PC, valid=0, fetch_count=0.
  - next edge latches PC 0 as valid.
